smg_bin2bcd_module: RTL and testbench
=====================================

Name: smg_bin2bcd_module

Overview:
Sequential binary-to-BCD converter placed directly upstream of the 7-segment digit scan controller. It converts an unsigned binary value to packed 4-digit BCD using the shift-add-3 (double-dabble) method, one bit per CLK1MS cycle. Its output Number_Sig drives the scan controller's 16-bit digit input. The output holds steady between conversions and changes only in a single atomic update, so the scanner never sees a partial value.

Parameters:
BIN_W, 14, width of binary input (max 16383)
DIGITS, 4, number of BCD digits produced; output width = 4*DIGITS
MAX_VAL, 9999, largest value representable (10^DIGITS - 1); saturation limit

Ports:
CLK1MS  in  1  system scan clock (1 ms tick)
RSTn  in  1  asynchronous, active-low reset
Start_Sig  in  1  request conversion; sampled only in IDLE
Bin_Data  in  BIN_W  unsigned binary value; captured on accepted Start_Sig
Number_Sig  out  4*DIGITS  packed BCD result, [15:12] thousands down to [3:0] units
Done_Sig  out  1  one-cycle pulse, coincident with Number_Sig update
Busy_Sig  out  1  high while a conversion is in progress
Ovf_Sig  out  1  result was saturated; updated together with Number_Sig

Behaviour:
- Reset (RSTn low, asynchronous): state=IDLE; Number_Sig=0, Done_Sig=0, Busy_Sig=0, Ovf_Sig=0; scratch and bit counter cleared.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: Done_Sig is deasserted on every IDLE edge unless a new DONE occurs. On an edge with Start_Sig=1: capture Bin_Data into the shift register, clear the BCD scratch, set cnt=0, set ovf_pend = (Bin_Data > MAX_VAL), set Busy_Sig=1, go to SHIFT.
- SHIFT: one iteration per edge. For each BCD nibble >=5, add 3 (combinational). Then shift {bcd, bin} left by 1 so the bin MSB enters the bcd LSB. cnt increments. After BIN_W iterations go to DONE.
- DONE (one edge): Number_Sig <= ovf_pend ? all-nines (0x9999) : bcd scratch; Ovf_Sig <= ovf_pend; Done_Sig <= 1; Busy_Sig <= 0; go to IDLE.
- Latency: Start_Sig accepted at edge k -> Number_Sig/Done_Sig valid after edge k+BIN_W+1 (15 for default). The earliest next accept is edge k+BIN_W+2, giving a period of BIN_W+2 cycles.
- Start_Sig while Busy_Sig=1 (SHIFT or DONE): ignored. It is not queued, and Bin_Data changes have no effect.
- Start_Sig held high continuously: back-to-back conversions every BIN_W+2 cycles, re-capturing Bin_Data each time.
- Number_Sig and Ovf_Sig hold their last values indefinitely between conversions.
- Arithmetic: scratch width is 4*DIGITS. Add-3 is applied per nibble with no carry between nibbles. Values <= MAX_VAL never overflow the scratch. Values > MAX_VAL use the saturated output, and their scratch contents are discarded.
- Reset mid-conversion: aborts the conversion immediately. All outputs return to reset values, and no Done_Sig is produced.

Decomposition:
- Shared package/include: DIGITS, BCD nibble width (4), MAX_VAL, state encodings (IDLE/SHIFT/DONE), bit-counter width clog2(BIN_W+1). The same DIGITS constant also sizes the downstream scan controller input.
- One sub-module: smg_bcd_adj_unit, a combinational per-nibble "if >=5 then +3" cell, instantiated DIGITS times via generate.

Test Plan:
- Bin_Data=1234, Start pulse at edge k -> Busy_Sig=1 edges k..k+14; Number_Sig=0x1234, Done_Sig=1 for exactly one cycle after edge k+15; Ovf_Sig=0.
- Bin_Data=0, then 9999 -> Number_Sig=0x0000, then 0x9999, with Ovf_Sig=0 both times. Also Bin_Data=7 -> 0x0007.
- Bin_Data=10000 and 16383 -> Number_Sig=0x9999, Ovf_Sig=1. A following conversion of 42 -> 0x0042, Ovf_Sig=0.
- Start with 1234, then Start pulses with Bin_Data=5678 at edges k+3 and k+15 (DONE) -> ignored; result 0x1234; only one Done_Sig pulse.
- Start held high with Bin_Data=321 then 654 -> Done_Sig pulses 16 cycles apart; Number_Sig 0x0321, then 0x0654, never an intermediate value.
- Result 0x1234 present, new conversion of 5678 started, RSTn asserted at cycle k+7 -> Number_Sig=0 immediately, no Done_Sig; after release, Start with 88 -> 0x0088.

Source files
------------

// File: rtl/smg_bin2bcd_module_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter that feeds
// the 7-segment scan controller.
package smg_bin2bcd_module_pkg;

    localparam int unsigned BIN_W   = 14;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned BCD_W   = NIB_W * DIGITS;
    localparam int unsigned MAX_VAL = 9999;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);

    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/smg_bcd_adj_unit.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 before the shift.
module smg_bcd_adj_unit
    import smg_bin2bcd_module_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [NIB_W-1:0] adj_c
);

    always_comb begin
        adj_c = nib;
        if (nib >= NIB_W'(5)) begin
            adj_c = nib + NIB_W'(3);
        end
    end

endmodule

// File: rtl/smg_bin2bcd_module.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per CLK1MS tick.
// Number_Sig/Ovf_Sig only change on the single DONE edge so the scanner never sees partial digits.
module smg_bin2bcd_module
    import smg_bin2bcd_module_pkg::*;
(
    input  logic             CLK1MS,
    input  logic             RSTn,
    input  logic             Start_Sig,
    input  logic [BIN_W-1:0] Bin_Data,
    output logic [BCD_W-1:0] Number_Sig,
    output logic             Done_Sig,
    output logic             Busy_Sig,
    output logic             Ovf_Sig
);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_q, bin_nxt;
    logic [BCD_W-1:0]   bcd_q, bcd_nxt;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               ovf_pend_q, ovf_pend_nxt;
    logic [BCD_W-1:0]   number_nxt;
    logic               done_nxt, busy_nxt, ovf_nxt;
    logic [BCD_W+BIN_W-1:0] shift_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        smg_bcd_adj_unit u_adj (
            .nib   (bcd_q[g*NIB_W +: NIB_W]),
            .adj_c (bcd_adj_c[g*NIB_W +: NIB_W])
        );
    end

    // Corrected scratch and remaining binary bits move left as one register pair.
    assign shift_c = {bcd_adj_c, bin_q} << 1;

    always_ff @(posedge CLK1MS or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            Number_Sig <= '0;
            Done_Sig   <= 1'b0;
            Busy_Sig   <= 1'b0;
            Ovf_Sig    <= 1'b0;
        end else begin
            state      <= state_nxt;
            bin_q      <= bin_nxt;
            bcd_q      <= bcd_nxt;
            cnt_q      <= cnt_nxt;
            ovf_pend_q <= ovf_pend_nxt;
            Number_Sig <= number_nxt;
            Done_Sig   <= done_nxt;
            Busy_Sig   <= busy_nxt;
            Ovf_Sig    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bin_nxt      = bin_q;
        bcd_nxt      = bcd_q;
        cnt_nxt      = cnt_q;
        ovf_pend_nxt = ovf_pend_q;
        number_nxt   = Number_Sig;
        done_nxt     = 1'b0;
        busy_nxt     = Busy_Sig;
        ovf_nxt      = Ovf_Sig;

        case (state)
            ST_IDLE: begin
                if (Start_Sig) begin
                    bin_nxt      = Bin_Data;
                    bcd_nxt      = '0;
                    cnt_nxt      = '0;
                    ovf_pend_nxt = (32'(Bin_Data) > MAX_VAL);
                    busy_nxt     = 1'b1;
                    state_nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_nxt = shift_c[BIN_W +: BCD_W];
                bin_nxt = shift_c[BIN_W-1:0];
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Saturated conversions discard the scratch, it may have wrapped.
                number_nxt = ovf_pend_q ? ALL_NINES : bcd_q;
                ovf_nxt    = ovf_pend_q;
                done_nxt   = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_smg_bin2bcd_module.sv
// Scoreboard bench for smg_bin2bcd_module: expected BCD results are queued at
// start and compared whenever Done_Sig is seen.
module tb_smg_bin2bcd_module;

    logic        CLK1MS = 1'b0;
    logic        RSTn = 1'b0;
    logic        Start_Sig = 1'b0;
    logic [13:0] Bin_Data = '0;
    logic [15:0] Number_Sig;
    logic        Done_Sig;
    logic        Busy_Sig;
    logic        Ovf_Sig;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_cyc_prev = 0;

    logic [16:0] exp_q[$];
    logic [15:0] last_num = '0;
    logic        last_ovf = 1'b0;
    logic        prev_done = 1'b0;

    smg_bin2bcd_module dut (
        .CLK1MS     (CLK1MS),
        .RSTn       (RSTn),
        .Start_Sig  (Start_Sig),
        .Bin_Data   (Bin_Data),
        .Number_Sig (Number_Sig),
        .Done_Sig   (Done_Sig),
        .Busy_Sig   (Busy_Sig),
        .Ovf_Sig    (Ovf_Sig)
    );

    always #5 CLK1MS = ~CLK1MS;
    always @(posedge CLK1MS) cyc++;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, saturating above 9999.
    function automatic logic [16:0] model(input int v);
        logic [15:0] r;
        if (v > 9999) return {1'b1, 16'h9999};
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return {1'b0, r};
    endfunction

    // Output monitor: scoreboard compare on Done, hold check otherwise.
    always @(negedge CLK1MS) begin
        logic [16:0] e;
        if (!RSTn) begin
            last_num  = Number_Sig;
            last_ovf  = Ovf_Sig;
            prev_done = Done_Sig;
        end else begin
            if (Done_Sig) begin
                done_cnt++;
                done_cyc_prev = done_cyc;
                done_cyc = cyc;
                check_value("done_pulse_width", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    check_value("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("number", 32'(Number_Sig), 32'(e[15:0]));
                    check_value("ovf", 32'(Ovf_Sig), 32'(e[16]));
                end
            end else begin
                if (Number_Sig != last_num) check_value("number_hold", 32'(Number_Sig), 32'(last_num));
                if (Ovf_Sig != last_ovf)    check_value("ovf_hold", 32'(Ovf_Sig), 32'(last_ovf));
            end
            last_num  = Number_Sig;
            last_ovf  = Ovf_Sig;
            prev_done = Done_Sig;
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_cnt < target; i++) @(negedge CLK1MS);
        if (done_cnt < target) check_value("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_conv(input int v);
        int target;
        @(negedge CLK1MS);
        Start_Sig = 1'b1;
        Bin_Data  = 14'(v);
        exp_q.push_back(model(v));
        target = done_cnt + 1;
        @(negedge CLK1MS);
        Start_Sig = 1'b0;
        wait_done(target);
    endtask

    initial begin
        int target;
        int base;

        // Reset state
        repeat (3) @(negedge CLK1MS);
        check_value("rst_number", 32'(Number_Sig), 32'h0);
        check_value("rst_done", 32'(Done_Sig), 32'd0);
        check_value("rst_busy", 32'(Busy_Sig), 32'd0);
        check_value("rst_ovf", 32'(Ovf_Sig), 32'd0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK1MS);

        // 1234 with cycle-exact Busy/Done timing
        Start_Sig = 1'b1;
        Bin_Data  = 14'd1234;
        exp_q.push_back(model(1234));
        target = done_cnt + 1;
        for (int i = 0; i <= 14; i++) begin
            @(negedge CLK1MS);
            if (i == 0) Start_Sig = 1'b0;
            check_value("busy_during", 32'(Busy_Sig), 32'd1);
            check_value("done_early", 32'(Done_Sig), 32'd0);
        end
        @(negedge CLK1MS);
        check_value("busy_after", 32'(Busy_Sig), 32'd0);
        check_value("done_at_k15", 32'(Done_Sig), 32'd1);
        check_value("number_1234", 32'(Number_Sig), 32'h1234);
        @(negedge CLK1MS);
        check_value("done_drop", 32'(Done_Sig), 32'd0);
        check_value("done_count_1", 32'(done_cnt), 32'(target));

        // Boundaries and saturation
        run_conv(0);
        run_conv(9999);
        run_conv(7);
        run_conv(10000);
        run_conv(16383);
        run_conv(42);
        for (int i = 0; i < 6; i++) run_conv(int'($urandom_range(0, 16383)));

        // Starts during SHIFT and DONE are ignored
        @(negedge CLK1MS);
        Start_Sig = 1'b1;
        Bin_Data  = 14'd1234;
        exp_q.push_back(model(1234));
        target = done_cnt + 1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge CLK1MS);
            Start_Sig = (i == 2 || i == 14);
            if (i == 2) Bin_Data = 14'd5678;
        end
        wait_done(target);
        repeat (20) @(negedge CLK1MS);
        check_value("ignored_start_dones", 32'(done_cnt), 32'(target));
        check_value("ignored_start_number", 32'(Number_Sig), 32'h1234);

        // Start held high: back-to-back conversions
        @(negedge CLK1MS);
        Start_Sig = 1'b1;
        Bin_Data  = 14'd321;
        exp_q.push_back(model(321));
        base = done_cnt;
        @(negedge CLK1MS);
        Bin_Data = 14'd654;
        exp_q.push_back(model(654));
        wait_done(base + 1);
        @(negedge CLK1MS);
        Start_Sig = 1'b0;
        wait_done(base + 2);
        check_value("b2b_period", 32'(done_cyc - done_cyc_prev), 32'd16);
        check_value("b2b_number", 32'(Number_Sig), 32'h0654);
        repeat (20) @(negedge CLK1MS);
        check_value("b2b_no_extra", 32'(done_cnt), 32'(base + 2));

        // Reset mid-conversion aborts without a Done
        run_conv(1234);
        @(negedge CLK1MS);
        Start_Sig = 1'b1;
        Bin_Data  = 14'd5678;
        @(negedge CLK1MS);
        Start_Sig = 1'b0;
        repeat (6) @(negedge CLK1MS);
        #3 RSTn = 1'b0;
        #1;
        check_value("abort_number", 32'(Number_Sig), 32'h0);
        check_value("abort_busy", 32'(Busy_Sig), 32'd0);
        check_value("abort_done", 32'(Done_Sig), 32'd0);
        check_value("abort_ovf", 32'(Ovf_Sig), 32'd0);
        base = done_cnt;
        repeat (3) @(negedge CLK1MS);
        #3 RSTn = 1'b1;
        repeat (25) @(negedge CLK1MS);
        check_value("abort_no_done", 32'(done_cnt), 32'(base));
        check_value("abort_hold_zero", 32'(Number_Sig), 32'h0);
        run_conv(88);
        check_value("after_abort_88", 32'(Number_Sig), 32'h0088);

        check_value("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
